// File: rtl/two_parallel_pkg.sv
// Shared widths, output bounds and the packed sample-pair type used by the
// two-parallel FIR output stage.
package two_parallel_pkg;

  localparam int IN_W_DEF  = 64;
  localparam int OUT_W_DEF = 16;

  localparam logic signed [OUT_W_DEF-1:0] OUT_MAX = 16'sh7FFF;
  localparam logic signed [OUT_W_DEF-1:0] OUT_MIN = 16'sh8000;

  typedef struct packed {
    logic signed [OUT_W_DEF-1:0] lane1;
    logic signed [OUT_W_DEF-1:0] lane2;
  } pair_t;

endpackage

// File: rtl/two_parallel_serializer_requant.sv
// Combinational requantizer: round-half-up arithmetic right shift by SHIFT,
// then saturation to OUT_W signed; sat flags a clipped sample.
module requant #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  localparam logic [IN_W:0] RND = ({{IN_W{1'b0}}, 1'b1} << SHIFT) >> 1;
  localparam logic signed [IN_W:0] HI =
    $signed({{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}});
  localparam logic signed [IN_W:0] LO = ~HI;

  // One guard bit keeps the rounding add from overflowing at the input extremes.
  function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] ext;
    ext = {x[IN_W-1], x};
    ext = ext + $signed(RND);
    return ext >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W:0] x);
    if (x > HI) return HI[OUT_W-1:0];
    if (x < LO) return LO[OUT_W-1:0];
    return x[OUT_W-1:0];
  endfunction

  logic signed [IN_W:0] w_shifted;

  assign w_shifted = round_shift(din);
  assign dout      = saturate(w_shifted);
  assign sat       = (w_shifted > HI) || (w_shifted < LO);

endmodule

// File: rtl/two_parallel_serializer.sv
// Requantizes parallel FIR output pairs, buffers them and emits one serial
// stream (lane1 then lane2). Define OVF_COUNT_EN to enable ovf_count.
module two_parallel_serializer
  import two_parallel_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 15,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  din1,
  input  logic signed [IN_W-1:0]  din2,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             ovf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic signed [OUT_W-1:0] w_q1, w_q2;
  logic                    w_sat1, w_sat2;

  requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_requant1 (
    .din (din1),
    .dout(w_q1),
    .sat (w_sat1)
  );

  requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_requant2 (
    .din (din2),
    .dout(w_q2),
    .sat (w_sat2)
  );

  pair_t          r_mem [DEPTH];
  pair_t          w_head;
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count, w_count_nxt;
  logic           r_phase, r_in_ready;
  logic           w_push, w_pop, w_empty;

  assign w_empty   = (r_count == '0);
  assign out_valid = !w_empty;
  assign in_ready  = r_in_ready;
  assign w_push    = in_valid && r_in_ready;
  assign w_pop     = out_valid && out_ready && r_phase;
  assign w_head    = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  // in_ready is a registered not-full flag, so a pop never re-opens it in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_phase    <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != CW'(DEPTH));
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      if (out_valid && out_ready)
        r_phase <= !r_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= '{lane1: w_q1, lane2: w_q2};
  end

  always_comb begin
    dout = '0;
    if (!w_empty)
      dout = r_phase ? w_head.lane2 : w_head.lane1;
  end

`ifdef OVF_COUNT_EN
  logic [15:0] r_ovf;
  logic [16:0] w_ovf_sum;

  assign w_ovf_sum = {1'b0, r_ovf} + 17'(w_sat1) + 17'(w_sat2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_ovf <= '0;
    else if (w_push)
      r_ovf <= w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
  end

  assign ovf_count = r_ovf;
`else
  logic w_sat_unused;
  assign w_sat_unused = w_sat1 ^ w_sat2;
  assign ovf_count    = '0;
`endif

endmodule

// File: tb/tb_two_parallel_serializer.sv
// Bench for two_parallel_serializer: directed vector table, backpressure,
// reset mid-pair and randomized streaming against a scoreboard model.
module tb_two_parallel_serializer;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [63:0] din1, din2;
  logic               in_valid, in_ready;
  logic signed [15:0] dout;
  logic               out_valid, out_ready;
  logic [15:0]        ovf_count;

  two_parallel_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .din1     (din1),
    .din2     (din2),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout     (dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int     n_pass = 0;
  int     n_total = 0;
  longint sb[$];
  longint exp_ovf = 0;

  typedef struct {
    logic signed [63:0] d1;
    logic signed [63:0] d2;
    longint             e1;
    longint             e2;
    int                 nsat;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: floor((x + 2^14) / 2^15) using exact wide division, then clamp.
  function automatic longint ref_q(input logic signed [63:0] x, output int sat);
    logic signed [79:0] t, q;
    t = x;
    t = t + 80'sd16384;
    q = t / 80'sd32768;
    if ((t % 80'sd32768) != 0 && t < 0) q = q - 1;
    sat = 0;
    if (q > 32767) begin sat = 1; return 32767; end
    if (q < -32768) begin sat = 1; return -32768; end
    return longint'(q);
  endfunction

  task automatic model_push(input logic signed [63:0] a, input logic signed [63:0] b);
    int s1, s2;
    sb.push_back(ref_q(a, s1));
    sb.push_back(ref_q(b, s2));
`ifdef OVF_COUNT_EN
    exp_ovf = exp_ovf + s1 + s2;
    if (exp_ovf > 65535) exp_ovf = 65535;
`endif
  endtask

  function automatic logic signed [63:0] rnd64();
    logic signed [63:0] v;
    v = {$urandom, $urandom};
    return v >>> $urandom_range(0, 63);
  endfunction

  initial begin
    int  acc, cyc, pushed;
    bit  prev_stall;
    longint prev_dout, held;

    vt[0] = '{64'sd3276800, -64'sd3276800, 100, -100, 0};
    vt[1] = '{64'sd16384, -64'sd16384, 1, 0, 0};
    vt[2] = '{64'sd49151, -64'sd49152, 1, -1, 0};
    vt[3] = '{64'sd1099511627776, -64'sd1099511627776, 32767, -32768, 2};
    vt[4] = '{64'sh7FFF_FFFF_FFFF_FFFF, 64'sh8000_0000_0000_0000, 32767, -32768, 2};
    vt[5] = '{64'sd1073709056, -64'sd1073741824, 32767, -32768, 0};
    vt[6] = '{64'sd1073725440, -64'sd1073758209, 32767, -32768, 2};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din1 = '0; din2 = '0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf_count, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Directed table: one pair at a time with the sink always ready.
    for (int i = 0; i < 7; i++) begin
      din1 = vt[i].d1; din2 = vt[i].d2; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("tbl_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
`ifdef OVF_COUNT_EN
      exp_ovf += vt[i].nsat;
`endif
      @(negedge clk);
      chk("tbl_valid1", out_valid, 1);
      chk("tbl_lane1", dout, vt[i].e1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tbl_lane2", dout, vt[i].e2);
      chk("tbl_ovf", ovf_count, exp_ovf);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tbl_drained", out_valid, 0);
      @(posedge clk); #1;
    end

    // Backpressure: fill the FIFO with the sink stalled.
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 8 && acc < 5; c++) begin
      din1 = 64'(acc + 1) * 64'sd32768000;
      din2 = -64'(acc + 1) * 64'sd229376;
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin model_push(din1, din2); acc++; end
      @(posedge clk); #1;
    end
    chk("bp_accepted", acc, 4);
    @(negedge clk);
    chk("bp_in_ready_full", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    held = dout;
    chk("bp_head", held, sb[0]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_stall_dout", dout, held);
      chk("bp_stall_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin
      @(negedge clk);
      if (out_valid) chk("bp_drain", dout, sb.pop_front());
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_drain_done", sb.size(), 0);

    // Reset after lane1 of a pair has been taken.
    din1 = 64'sd163840; din2 = 64'sd196608; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    sb.delete(); exp_ovf = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    din1 = 64'sd229376; din2 = 64'sd262144; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_repush_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_first_valid", out_valid, 1);
    chk("rst_first_lane1", dout, 7);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_first_lane2", dout, 8);
    @(posedge clk); #1;

    // Randomized streaming against the scoreboard.
    pushed = 0; cyc = 0; prev_stall = 0; prev_dout = 0;
    while ((pushed < 1000 || sb.size() != 0) && cyc < 30000) begin
      in_valid  = (pushed < 1000) && ($urandom_range(0, 1) == 1);
      din1      = rnd64();
      din2      = rnd64();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_dout", dout, prev_dout);
        chk("stall_valid", out_valid, 1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("stream_extra", 1, 0);
        else chk("stream_dout", dout, sb.pop_front());
      end
      if (in_valid && in_ready) begin
        model_push(din1, din2);
        pushed++;
      end
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_no_timeout", (cyc < 30000), 1);
    chk("stream_pairs", pushed, 1000);
    @(negedge clk);
    chk("stream_empty", out_valid, 0);
    chk("stream_ovf", ovf_count, exp_ovf);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
